// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmitter and the keyboard
// receiver.
//   tx_state_e     - host-to-device transmitter FSM states
//   CMD_* / RSP_*  - common keyboard command and response bytes
//   FRAME_W        - width of the host frame shift register (data+parity+stop)
//   CNT_W          - width of the saturating timeout / inhibit counter
//   odd_parity()   - PS/2 odd-parity bit for a data byte
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    ERROR
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int FRAME_W   = 10;
  localparam int CNT_W     = 20;
  localparam int BIT_CNT_W = 4;

  // Odd parity: the parity bit makes the total count of ones in
  // data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchroniser and falling-edge detector for one PS/2 line.
// The raw pin is passed through SYNC_STAGES flops; fall_o is a one-cycle
// strobe on a synchronised 1->0 transition. Flops reset to 1 (idle bus).
//   clk_i    in   system clock
//   rst_ni   in   asynchronous reset, active low
//   line_i   in   raw pin level (asynchronous)
//   level_o  out  synchronised line level
//   fall_o   out  one-cycle strobe on a synchronised falling edge
// SYNC_STAGES must be at least 2.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to
// the keyboard using the open-drain host-request sequence (inhibit clock,
// pull data low, release clock, shift bits on device falling edges) and
// then checks the device ACK bit.
//   CLOCK_50    in   system clock (50 MHz)
//   reset       in   asynchronous reset, active low
//   tx_valid    in   request to send tx_data
//   tx_data     in   command byte
//   tx_ready    out  high only in IDLE; accept on tx_valid && tx_ready
//   tx_done     out  one-cycle pulse: frame sent and ACK seen low
//   tx_error    out  one-cycle pulse: timeout or missing ACK
//   busy        out  high in every state except IDLE
//   rx_inhibit  out  equals busy; keyboard receiver ignores the bus
//   ps2_clk_in  in   raw PS2_CLK level
//   ps2_dat_in  in   raw PS2_DAT level
//   ps2_clk_oe  out  1 = pull CLK low, 0 = release
//   ps2_dat_oe  out  1 = pull DAT low, 0 = release
//
// Handshake: a byte is taken on the rising CLOCK_50 edge where tx_valid and
// tx_ready are both high; tx_valid outside IDLE is ignored, not queued.
// Exactly one of tx_done / tx_error pulses per accepted byte (unless reset
// intervenes), in the last busy cycle; tx_ready rises on the next cycle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INH_LIM   = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // --------------------------------------------------------------------
  // Line synchronisers
  // --------------------------------------------------------------------
  logic clk_lvl;
  logic clk_fall;
  logic dat_lvl;
  logic dat_fall_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset),
    .line_i  (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset),
    .line_i  (ps2_dat_in),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  tx_state_e              state_q, state_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Saturating increment: a stuck bus must never wrap the counter back
  // below a timeout limit.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // --------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------
  // cnt_q holds the number of cycles elapsed since the current reference
  // point (entry to INHIBIT/START, or the last device fall). On a fall it
  // loads 1 because the strobe cycle itself is the first elapsed cycle,
  // so a timeout lands exactly BIT_TIMEOUT cycles after the strobe.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_inc;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        // Falls produced by our own clock pull-down are ignored here.
        ps2_clk_oe = 1'b1;
        if (cnt_q >= INH_LIM) begin
          // One overlap cycle: DAT goes low before CLK is released.
          ps2_dat_oe = 1'b1;
          cnt_d      = '0;
          state_d    = START;
        end
      end

      START: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          // Bit 0 is already at shift_q[0]; DATA drives it from now on.
          bit_cnt_d = '0;
          cnt_d     = CNT_W'(1);
          state_d   = DATA;
        end else if (cnt_inc >= START_LIM) begin
          state_d = ERROR;
        end
      end

      DATA: begin
        ps2_dat_oe = ~shift_q[0];
        if (clk_fall) begin
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          cnt_d   = CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (cnt_inc >= BIT_LIM) begin
          state_d = ERROR;
        end
      end

      PARITY: begin
        ps2_dat_oe = ~shift_q[0];
        if (clk_fall) begin
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = STOP;
        end else if (cnt_inc >= BIT_LIM) begin
          state_d = ERROR;
        end
      end

      STOP: begin
        // Stop bit (1) is now at shift_q[0], so DAT is released. This state
        // lasts one cycle; the next device fall carries the ACK.
        ps2_dat_oe = ~shift_q[0];
        if (cnt_inc >= BIT_LIM) begin
          state_d = ERROR;
        end else begin
          state_d = ACK;
        end
      end

      ACK: begin
        if (clk_fall) begin
          cnt_d   = CNT_W'(1);
          state_d = dat_lvl ? ERROR : WAIT_IDLE;
        end else if (cnt_inc >= BIT_LIM) begin
          state_d = ERROR;
        end
      end

      WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_inc >= BIT_LIM) begin
          state_d = ERROR;
        end
      end

      ERROR: begin
        tx_error = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rx_inhibit = busy;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending end of the keyboard link, paired with the keyboard receiver.
- Sends one command byte to the keyboard (e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable) using the open-drain PS/2 host-request protocol, then checks the device ACK bit.
- Sits between game control logic and the PS2_CLK/PS2_DAT pins (driven through tri-state pads at top level).
- Asserts rx_inhibit while it owns the bus so the receiver discards edges it generates.

Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit time in CLOCK_50 cycles (120 us; must be at least 5000).
- START_TIMEOUT, 750000: maximum cycles from releasing CLK to the first device falling edge (15 ms).
- BIT_TIMEOUT, 10000: maximum cycles between consecutive device falling edges (200 us).
- SYNC_STAGES, 2: flop stages used to synchronise the PS/2 inputs.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received low.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.
- busy  out  1  high in every state except IDLE.
- rx_inhibit  out  1  equals busy; the receiver ignores the bus while it is high.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull CLK low; 0 = release (high-Z).
- ps2_dat_oe  out  1  1 = pull DAT low; 0 = release.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state IDLE; both oe outputs 0 immediately.
  - tx_done = 0, tx_error = 0, busy = 0.
  - All counters cleared; shift register cleared.
- Inputs pass through SYNC_STAGES flops. A "fall" is a one-cycle strobe on a synchronised 1->0 transition of CLK.
- Accept: on a cycle with tx_valid && tx_ready, latch {stop=1, parity=~^tx_data, tx_data} into an 10-bit shift register and go to INHIBIT.
  - tx_valid while busy is ignored, not queued.
- INHIBIT:
  - clk_oe = 1, dat_oe = 0 for exactly INHIBIT_CYCLES cycles.
  - Then dat_oe = 1 (start bit), and on the next cycle clk_oe = 0. Go to START.
- START:
  - Hold dat_oe = 1 and count cycles.
  - First fall: drive bit 0; go to DATA with bit_cnt = 0.
  - Count reaching START_TIMEOUT: go to ERROR.
- DATA, PARITY, STOP: on each fall, shift out the next bit with dat_oe = ~bit. The sequence of falls is:
  - falls 1-8: data bits, LSB first (DATA, bit_cnt 0..7).
  - fall 9: parity (PARITY).
  - fall 10: stop bit, dat_oe = 0 (STOP). Go to ACK.
  - The timeout counter clears on every fall; reaching BIT_TIMEOUT goes to ERROR.
- ACK:
  - On fall 11, sample synchronised DAT. 0 -> go to WAIT_IDLE with ack_ok. 1 -> go to ERROR.
  - Reaching BIT_TIMEOUT goes to ERROR.
- WAIT_IDLE:
  - Wait until synchronised CLK and DAT are both 1.
  - Then pulse tx_done and go to IDLE.
  - Reaching BIT_TIMEOUT pulses tx_error instead.
- ERROR: both oe outputs 0, pulse tx_error for one cycle, go to IDLE.
- tx_done and tx_error are never high in the same cycle. tx_ready returns the cycle after the pulse.
- Fall strobes seen in IDLE or INHIBIT are ignored.
- Width rules:
  - Timeout counter is 20 bits and saturates; it does not wrap.
  - bit_cnt is 4 bits.
- Reset mid-frame: the bus is released asynchronously and no pulse is issued.

Decomposition:
- Package ps2_pkg holds:
  - tx state enum: IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE, ERROR.
  - command constants: CMD_SET_LEDS 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, RSP_ACK 8'hFA.
- Sub-module ps2_line_sync: synchroniser plus falling-edge strobe for one line, instantiated twice. The keyboard receiver can reuse it.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs. Required: clk_oe high for 6000 cycles; DAT sampled on device rising edges reads 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_error stays 0.
- Parity sweep 0x00, 0x01, 0xFF. Required parity bits 1, 0, 1.
- Device never clocks. Required: tx_error pulses exactly START_TIMEOUT cycles after clk_oe falls; both oe = 0; tx_ready = 1 on the next cycle.
- Device clocks but holds DAT high at fall 11 (NACK). Required: tx_error pulse, no tx_done.
- Device stops after fall 5. Required: tx_error BIT_TIMEOUT cycles after fall 5.
- Assert tx_valid = 1 with 0x55 during DATA. Required: ignored, frame still carries the original byte.
- Drive reset = 0 mid-DATA. Required: clk_oe = dat_oe = 0 within the same cycle with no clock edge; busy = 0.
